// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one external LAT-stage signed multiplier among N_REQ requesters.
// Latency: accept in cycle T -> mul_en at T+1 -> product captured at T+1+LAT -> rsp_valid at T+LAT+2.
// Backpressure: credits cap issued-plus-buffered products at DEPTH; req_ready drops to zero without a credit.
module booth_mul_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 10,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  output logic                       mul_en,
  input  logic [2*WIDTH-1:0]         mul_p,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]         rsp_data
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(DEPTH);
  localparam int PRW = 2 * WIDTH;
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);
  localparam logic [PW:0]    DEPTH_C = (PW + 1)'(DEPTH);

  // In-flight tag travelling beside the multiplier pipeline.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  // One buffered response.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [PRW-1:0] prod;
  } ent_t;

  // Circular index base+off, with off in 1..N_REQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic           pop;
  logic           credit_ok;
  logic           grant;
  logic [PW:0]    cnt;
  logic [IDW-1:0] issue_id;

  tag_t           tag_q [LAT];
  tag_t           tag_out;
  logic           wr_en;

  ent_t           mem [DEPTH];
  ent_t           wr_ent;
  ent_t           head_nxt;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  rd_ptr_nxt;
  logic [PW:0]    fifo_cnt;
  logic [PW:0]    cnt_after_pop;
  logic [PW:0]    fifo_cnt_nxt;

  // Pick the first requesting index after the round-robin pointer, circularly.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_found && req_valid[rr_idx(rr_ptr, i)]) begin
        win_found = 1'b1;
        win_id    = rr_idx(rr_ptr, i);
      end
    end
  end

  assign pop       = rsp_valid & rsp_ready;
  // A pop in this cycle frees its slot for a grant in the same cycle.
  assign credit_ok = (cnt < DEPTH_C) | pop;
  assign grant     = win_found & credit_ok;

  // Only the winner sees ready, and only while a credit is available.
  always_comb begin
    req_ready         = '0;
    req_ready[win_id] = grant;
  end

  // Credit count (issued-but-unwritten plus buffered) and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rr_ptr <= LAST_ID;
    end else begin
      if (grant) rr_ptr <= win_id;
      case ({grant, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Launch the accepted operand pair; operands hold their last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_en   <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      issue_id <= '0;
    end else begin
      mul_en <= grant;
      if (grant) begin
        mul_a    <= req_a[win_id*WIDTH +: WIDTH];
        mul_b    <= req_b[win_id*WIDTH +: WIDTH];
        issue_id <= win_id;
      end
    end
  end

  // Delay {valid, id} by LAT cycles so it meets its product on mul_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {mul_en, issue_id};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[LAT-1];
  assign wr_en   = tag_out.vld;
  assign wr_ent  = {tag_out.id, mul_p};

  // Storage array; occupancy lives in the pointers so no reset is needed here.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_ent;
  end

  // Next head: bypass the incoming product when it lands in an otherwise empty FIFO.
  always_comb begin
    rd_ptr_nxt    = rd_ptr + PW'(pop);
    cnt_after_pop = fifo_cnt - (PW + 1)'(pop);
    fifo_cnt_nxt  = cnt_after_pop + (PW + 1)'(wr_en);
    head_nxt      = (cnt_after_pop == '0) ? wr_ent : mem[rd_ptr_nxt];
  end

  // FIFO pointers, occupancy and the registered head seen by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_nxt;
      fifo_cnt  <= fifo_cnt_nxt;
      rsp_valid <= (fifo_cnt_nxt != '0);
      if (fifo_cnt_nxt != '0) begin
        rsp_id   <= head_nxt.id;
        rsp_data <= head_nxt.prod;
      end
    end
  end

endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Round-robin scheduler that shares one pipelined radix-4 Booth multiplier among N_REQ requesters.
- The multiplier is the Booth encoder plus Dadda tree plus final carry-select adder, registered to LAT stages.
- The block accepts operand pairs over valid/ready and issues at most one pair per cycle.
- It tracks in-flight products with a tag pipeline and returns each product, tagged with the requester id, through a credit-guarded response FIFO.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 10, signed operand width; product width is 2*WIDTH.
- LAT, 2, multiplier latency in cycles from mul_a/mul_b to mul_p (1..4).
- DEPTH, 4, response FIFO depth; also the maximum number of outstanding products (power of 2, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept (one-hot or zero).
- req_a  in  N_REQ*WIDTH  packed multiplicands; requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  packed multipliers; same packing as req_a.
- mul_a  out  WIDTH  registered operand A to the multiplier.
- mul_b  out  WIDTH  registered operand B to the multiplier.
- mul_en  out  1  registered; high in the cycle mul_a/mul_b carry a valid pair.
- mul_p  in  2*WIDTH  signed product from the multiplier, LAT cycles after mul_en.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  clog2(N_REQ)  requester index of the head product.
- rsp_data  out  2*WIDTH  signed product.

Behaviour:
- Reset values (asynchronous):
  - mul_en=0, mul_a=0, mul_b=0.
  - Tag pipeline cleared; FIFO empty, so rsp_valid=0, rsp_id=0, rsp_data=0.
  - Credit count=0; RR pointer=N_REQ-1, so requester 0 has first priority.
- Reset mid-operation: all in-flight and buffered products are discarded; no response is emitted for them.
- Credit:
  - cnt = number of issued-but-not-yet-written products + FIFO occupancy, range 0..DEPTH.
  - pop = rsp_valid & rsp_ready.
  - Grant is allowed when cnt - pop < DEPTH; a pop in the same cycle frees a slot for a grant in that cycle.
  - cnt_next = cnt + grant - pop.
- Arbitration (combinational):
  - Among req_valid bits, pick the first index after the RR pointer, circularly.
  - req_ready[g]=1 only for the winner, and only when credit is allowed; otherwise req_ready=0.
  - On a handshake the RR pointer updates to g. With no grant the pointer holds.
  - req_valid must not depend on req_ready. A requester holds valid and operands until accepted.
- Issue:
  - A handshake in cycle T registers req_a[g]/req_b[g] to mul_a/mul_b and sets mul_en=1 in T+1.
  - With no handshake, mul_en=0 and mul_a/mul_b hold their last value.
- Tag pipeline:
  - LAT-deep shift register of {valid, id}, loaded alongside mul_en.
  - Its output is aligned with mul_p in cycle T+1+LAT.
  - When the output valid is set, mul_p and id are written into the FIFO at the end of that cycle.
- FIFO:
  - DEPTH entries with wrap-around read/write pointers.
  - Simultaneous write and pop is supported, including when the FIFO is full: the pop frees the slot.
  - The credit rule guarantees a write never hits a full FIFO. A write into a full FIFO is a design error; the bench checks it with an assertion.
  - rsp_valid, rsp_id and rsp_data are registered.
  - The earliest rsp_valid for an accept in cycle T is cycle T+LAT+2.
- Throughput and ordering:
  - Steady state is 1 product per cycle when rsp_ready is held high.
  - Responses are returned in issue order.
- Arithmetic: no truncation. Products are full 2*WIDTH two's complement, passed through unchanged.

Test Plan:
- Single request: req 0 sends a=3, b=-5 at cycle T, rsp_ready=1 → mul_en=1 with mul_a=3 at T+1; rsp_valid at T+4 (LAT=2) with rsp_id=0, rsp_data=20'hFFFF1.
- Round-robin fairness: all 4 req_valid held high for 8 cycles, rsp_ready=1 → grants in order 0,1,2,3,0,1,2,3, one per cycle, and responses come back in the same id order.
- Backpressure: rsp_ready=0 with all requesters valid → exactly DEPTH=4 handshakes, then req_ready=0 while mul_en drains. Raising rsp_ready for 1 cycle → exactly one new grant in that same cycle.
- Full with simultaneous pop: cnt=4 and rsp_ready=1 → a grant occurs the same cycle and cnt stays 4. No FIFO overflow assertion fires.
- Extremes: a=b=-512 → rsp_data=20'h40000. a=-512, b=511 → 20'hC0200. a=0, b=-1 → 0.
- Reset mid-operation: assert rst with 3 products in flight → rsp_valid=0 immediately and no stale response after release. The first grant after release goes to requester 0.
